// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access sizes,
// FSM states and the default data memory depth.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEPTH_DEFAULT = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_t;

  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

  // Encoding 2'b11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extraction with sign/zero extension,
// and byte/halfword insertion into an old word for read-modify-write stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_lane,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [15:0] st_wdata,
  input  logic [1:0]  st_lane,
  input  logic [1:0]  st_size,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
    ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  // Halfwords always land on the aligned-down half selected by lane[1].
  always_comb begin
    st_word = st_old;
    case (st_size)
      SZ_BYTE: st_word[{st_lane, 3'b000} +: 8]     = st_wdata[7:0];
      SZ_HALF: st_word[{st_lane[1], 4'b0000} +: 16] = st_wdata;
      default: st_word = st_old;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-to-word addressing, two-cycle sub-word
// read-modify-write stores with stall, registered load writeback.
// Optional build macro: MISALIGN_CHECK_EN rejects misaligned half/word accesses.
//
// state | meaning
// IDLE  | accept requests; loads and word stores complete here
// MERGE | write the merged word of a sub-word store; request inputs ignored
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        addr_err
);

  lsu_state_t  state, state_next;

  logic [29:0] req_index;
  logic        in_range;
  logic        misaligned;
  logic        req_bad;

  logic        load_ok;
  logic        err_next;
  logic        capture;

  logic [29:0] lat_index;
  logic [31:0] lat_old;
  logic [1:0]  lat_lane;
  logic [1:0]  lat_size;
  logic [15:0] lat_wdata;

  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_index = req_addr[31:2];
  assign in_range  = ({2'b00, req_index} < 32'(DEPTH));

`ifdef MISALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_bad = !in_range || misaligned;

  lsu_align u_align (
    .ld_word   (mem_rdata),
    .ld_lane   (req_addr[1:0]),
    .ld_size   (req_size),
    .ld_signed (req_signed),
    .ld_data   (load_data),
    .st_old    (lat_old),
    .st_wdata  (lat_wdata),
    .st_lane   (lat_lane),
    .st_size   (lat_size),
    .st_word   (merged_word)
  );

  // Memory strobes are gated by reset so an in-flight MERGE write is aborted.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = {2'b00, req_index};
    mem_wdata  = req_wdata;
    load_ok    = 1'b0;
    err_next   = 1'b0;
    capture    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              err_next = 1'b1;
            end else if (!req_write) begin
              mem_read = 1'b1;
              load_ok  = 1'b1;
            end else if (is_subword(req_size)) begin
              mem_read   = 1'b1;
              stall      = 1'b1;
              capture    = 1'b1;
              state_next = MERGE;
            end else begin
              mem_write = 1'b1;
            end
          end
        end
        MERGE: begin
          mem_addr   = {2'b00, lat_index};
          mem_wdata  = merged_word;
          mem_write  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wb_valid  <= 1'b0;
      wb_data   <= 32'h0;
      wb_rd     <= 5'd0;
      addr_err  <= 1'b0;
      lat_index <= 30'd0;
      lat_old   <= 32'h0;
      lat_lane  <= 2'b00;
      lat_size  <= SZ_BYTE;
      lat_wdata <= 16'h0;
    end else begin
      state    <= state_next;
      wb_valid <= load_ok;
      addr_err <= err_next;
      if (load_ok) begin
        wb_data <= load_data;
        wb_rd   <= req_rd;
      end
      if (capture) begin
        lat_index <= req_index;
        lat_old   <= mem_rdata;
        lat_lane  <= req_addr[1:0];
        lat_size  <= req_size;
        lat_wdata <= req_wdata[15:0];
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting between the EX/MEM pipeline register and the word-addressed data memory (256 × 32-bit, indexed by word, combinational read, synchronous write). It converts byte addresses to word indices, performs byte/halfword stores as a two-cycle read-modify-write with a pipeline stall, and extracts/sign-extends sub-word loads. It registers the result toward the MEM/WB register.

## Interface
- DEPTH, 256: data memory depth in words.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  memory request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for sub-word stores.
- req_rd  in  5  destination register, loads only.
- stall  out  1  upstream must hold the request and freeze the pipeline.
- mem_addr  out  32  word index to data memory.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word.
- mem_read  out  1  read enable.
- mem_write  out  1  write enable.
- wb_valid  out  1  registered load result valid.
- wb_data  out  32  registered load result.
- wb_rd  out  5  registered destination.
- addr_err  out  1  registered one-cycle error pulse.

## Operation
- Byte order: little-endian; lane = req_addr[1:0], byte 0 = bits 7:0. Word index = req_addr[31:2]. An index ≥ DEPTH is out of range.
- FSM states: IDLE, MERGE.
- IDLE behaviour by request type:
  - Load: mem_read=1 and mem_addr=index in the same cycle. Extract the lane, then zero-extend or sign-extend. On the clock edge, register the result into wb_data/wb_rd with wb_valid=1.
  - Word store: mem_write=1, mem_wdata=req_wdata, single cycle.
  - Sub-word store: mem_read=1 and stall=1 combinationally. On the edge, latch mem_rdata, address, size and data, then go to MERGE.
- MERGE:
  - mem_write=1 with the merged word: latched old word with the target byte or half lane replaced. stall=0.
  - The request inputs are ignored; the upstream advances on this edge. Return to IDLE.
- Out-of-range request: no mem_read or mem_write, no wb_valid; addr_err=1 on the next cycle.
- Stores never assert wb_valid.
- While no request is present: mem_read, mem_write and stall are all 0. The wb_valid and addr_err pulses are deasserted the following cycle.

## Timing
- Reset values: state IDLE, stall 0, wb_valid 0, wb_data 0, wb_rd 0, addr_err 0. mem_read and mem_write are 0 while in reset.
- Load latency: 1 cycle from request to wb_valid.
- Word store: 0 extra cycles; memory is updated at the request edge.
- Sub-word store: occupies 2 cycles with exactly 1 stall cycle; memory is updated at the MERGE edge.
- A request presented in the MERGE cycle is not accepted; it is re-presented in the next cycle.
- Reset asserted during MERGE: the write is aborted and memory is unchanged. State returns to IDLE and all outputs take their reset values.
- mem_addr is combinational: it follows the request in IDLE and the latched index in MERGE.

## Configuration
- MISALIGN_CHECK_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, is rejected.
  - No memory access and no wb_valid; addr_err pulses 1 cycle later.
- Undefined: the misaligned low address bits are ignored, so the access is forced to the aligned-down halfword or word. addr_err flags out-of-range only.

## Structure
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum {IDLE, MERGE};
  - the DEPTH default.
- One sub-module, lsu_align, is combinational and contains:
  - load lane extraction and sign/zero extension;
  - store lane merge.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word 0x10 → memory word[4]=0xDEADBEEF; next cycle wb_valid=1, wb_data=0xDEADBEEF, no stall.
- Word[4]=0x11223344; store byte 0xAB at 0x13 → stall for 1 cycle, word[4]=0xAB223344. Then:
  - load signed byte 0x13 → 0xFFFFFFAB;
  - load unsigned byte 0x13 → 0x000000AB.
- Word[2]=0; store half 0x8001 at 0x0A → word[2]=0x80010000. Then:
  - load signed half 0x0A → 0xFFFF8001;
  - load unsigned half 0x0A → 0x00008001.
- Load word 0x06 with word[1]=0x55:
  - with MISALIGN_CHECK_EN → addr_err=1, wb_valid=0;
  - without → wb_data=0x55.
- Store word to 0x400 (index 256) → addr_err=1 next cycle, no mem_write, memory unchanged.
- Store byte, then assert reset during MERGE → target word unchanged; stall=0, wb_valid=0, state IDLE.
